reg_write_arbiter: RTL
======================

// Module: reg_write_arbiter
// PURPOSE
//  Shares one 32-bit write-enabled register between NUM_REQ requesters (e.g. EX result,
//  MUL/DIV unit, exception logic writing a shared HI/LO/CP0-style register).
//  Round-robin arbitration with req/gnt handshake and optional locked bursts.
//  Drives the register's in_wena/in_data; the register captures on the following negedge.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  DATA_W     32  data width, matches the target register
//  BURST_MAX  4   max consecutive locked transfers before forced release (>=1)
// PORTS
//  in_clk     in   1               clock; arbiter state updates on posedge
//  in_rst     in   1               asynchronous reset, active-high
//  in_req     in   NUM_REQ         per-requester write request, held until granted
//  in_lock    in   NUM_REQ         requester wants to keep ownership after this transfer
//  in_data    in   NUM_REQ*DATA_W  requester i's data at [i*DATA_W +: DATA_W]
//  out_gnt    out  NUM_REQ         one-hot grant, combinational; transfer = in_req[i]&out_gnt[i]
//  out_wena   out  1               registered write enable to the target register
//  out_data   out  DATA_W          registered write data to the target register
//  out_owner  out  $clog2(NUM_REQ) index of the last granted requester
//  out_locked out  1               high while in LOCKED state
// BEHAVIOUR
//  Reset (async, in_rst=1): state=ARB, rr_ptr=NUM_REQ-1, burst_cnt=0, out_wena=0,
//   out_data=0, out_owner=0, out_locked=0; out_gnt=0 while in_rst is high.
//  Grant (combinational, at most one bit set, never to a requester with in_req low):
//   ARB: first requester with in_req high, scanning from rr_ptr+1 modulo NUM_REQ.
//   LOCKED: owner granted if in_req[owner]=1; otherwise fall back to ARB scan that cycle.
//  Transfer at posedge where in_req[i]&out_gnt[i]: out_wena<=1, out_data<=in_data[i],
//   out_owner<=i, rr_ptr<=i. No transfer: out_wena<=0, out_data held.
//  Latency: request seen in cycle k -> out_wena/out_data valid all of cycle k+1 -> register
//   loads at negedge of cycle k+1. Back-to-back transfers sustain one write per cycle.
//  Requester must keep in_req and its in_data stable until granted; dropping in_req before
//   grant withdraws the request with no write.
//  FSM transitions (posedge):
//   ARB->LOCKED: transfer by i with in_lock[i]=1 and BURST_MAX>1; burst_cnt<=1.
//   LOCKED->LOCKED: owner transfers, in_lock[owner]=1, burst_cnt<BURST_MAX-1; burst_cnt++.
//   LOCKED->ARB: owner transfers with in_lock low, or burst_cnt==BURST_MAX-1 (forced
//    release; rr_ptr=owner so owner gets lowest priority next), or owner's in_req low
//    (release, any other grant that cycle is an ordinary ARB transfer); burst_cnt<=0.
//  in_lock ignored unless the same requester transfers that cycle.
//  rr_ptr wrap: NUM_REQ-1 -> 0. burst_cnt width $clog2(BURST_MAX)+1, never exceeds BURST_MAX-1.
//  Reset mid-burst: drops to ARB immediately, out_wena=0 (pending write in flight is lost).
//  No requests: out_gnt=0, out_wena=0 next cycle, state unchanged in ARB.
// STRUCTURE
//  Shared package/header: FSM state encodings (ST_ARB, ST_LOCKED), DATA_W default.
//  One sub-module: rr_pick (combinational round-robin picker: req vector + pointer ->
//   one-hot grant, valid), reused by other arbiters in the design.
//  Top holds FSM, rr_ptr, burst_cnt, output registers; instantiates the register separately.
// TESTING
//  1 Reset then in_req=4'b0101 held -> gnt 0001, next cycle 0100, then 0001 (alternates);
//    register reads in_data[0], then in_data[2] after each negedge.
//  2 Single req1, data 32'hDEAD_BEEF -> out_wena=1 exactly one cycle later,
//    out_data=DEADBEEF, out_owner=1; register holds DEADBEEF after negedge.
//  3 req0 with in_lock=1 held, req3 waiting, BURST_MAX=4 -> 4 grants to 0, then forced
//    release, gnt 1000 on 5th cycle, out_locked high for cycles 2-4 only.
//  4 Locked owner 2 drops in_req while req1 high -> gnt 0010 same cycle, state ARB.
//  5 in_rst asserted mid-burst (async, between edges) -> out_wena, out_locked, out_gnt go 0
//    immediately; after release req0 wins first (rr_ptr=NUM_REQ-1).
//  6 All req high, no lock, 8 cycles -> grants 0,1,2,3,0,1,2,3; out_wena high every cycle.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_write_arbiter_pkg
// Brief  : Shared FSM encodings and defaults for the register write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package reg_write_arbiter_pkg;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int DEF_DATA_W = 32;

endpackage : reg_write_arbiter_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker, scans from ptr+1 modulo NUM_REQ.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : reg_write_arbiter
// Brief  : Round-robin write arbiter with locked bursts for one shared register.
// Rev    : 1.0  initial release
// ============================================================================
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [NUM_REQ-1:0]          in_req,
  input  logic [NUM_REQ-1:0]          in_lock,
  input  logic [NUM_REQ*DATA_W-1:0]   in_data,
  output logic [NUM_REQ-1:0]          out_gnt,
  output logic                        out_wena,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_REQ)-1:0]  out_owner,
  output logic                        out_locked
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam logic [CNT_W-1:0] c_burst_last = CNT_W'(BURST_MAX - 1);
  localparam logic             c_lock_en    = (BURST_MAX > 1);

  logic [0:0]         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [PTR_W-1:0]   r_owner;
  logic               r_wena;
  logic [DATA_W-1:0]  r_data;

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic               w_pick_valid;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_own_hold;
  logic               w_xfer;
  logic [PTR_W-1:0]   w_xidx;
  logic [DATA_W-1:0]  w_xdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (in_req),
    .ptr   (r_rr_ptr),
    .gnt   (w_pick_gnt),
    .valid (w_pick_valid)
  );

  // A locked owner keeps the grant only while it still requests; otherwise the
  // normal round-robin scan takes over in the same cycle.
  assign w_own_hold = (r_state == ST_LOCKED) && in_req[r_owner];

  always_comb begin
    w_gnt = '0;
    if (!in_rst) begin
      if (w_own_hold) begin
        w_gnt[r_owner] = 1'b1;
      end else if (w_pick_valid) begin
        w_gnt = w_pick_gnt;
      end
    end
  end

  always_comb begin
    w_xidx  = '0;
    w_xdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_xidx  = PTR_W'(i);
        w_xdata = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_xfer = |(in_req & w_gnt);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state     <= ST_ARB;
      r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
      r_burst_cnt <= '0;
      r_owner     <= '0;
      r_wena      <= 1'b0;
      r_data      <= '0;
    end else begin
      r_wena <= w_xfer;
      if (w_xfer) begin
        r_data   <= w_xdata;
        r_owner  <= w_xidx;
        r_rr_ptr <= w_xidx;
      end
      case (r_state)
        ST_ARB: begin
          if (w_xfer && in_lock[w_xidx] && c_lock_en) begin
            r_state     <= ST_LOCKED;
            r_burst_cnt <= CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (w_own_hold && in_lock[r_owner] && (r_burst_cnt < c_burst_last)) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
          end else begin
            r_state     <= ST_ARB;
            r_burst_cnt <= '0;
          end
        end
        default: begin
          r_state     <= ST_ARB;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  assign out_gnt    = w_gnt;
  assign out_wena   = r_wena;
  assign out_data   = r_data;
  assign out_owner  = r_owner;
  assign out_locked = (r_state == ST_LOCKED);

endmodule : reg_write_arbiter
`default_nettype wire
